reorder_buffer: RTL and testbench

- In-order retirement buffer for the out-of-order MIPS core.
- Allocates one entry per dispatched instruction and returns a ROB tag to the register rename stage.
- Marks entries complete on execution writeback and retires them in program order.
- On retirement, signals rename to mark the physical register ready and to free the superseded mapping; on a branch mispredict it squashes every entry younger than the branch.

---
 rtl/rob_pkg.sv | 20 ++
 rtl/reorder_buffer.sv | 84 ++++++++
 tb/tb_reorder_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared reorder-buffer constants, tag/entry types and tag age compare
package rob_pkg;
  localparam int ROB_DEPTH      = 16;
  localparam int ROB_DEPTH_BITS = 4;
  localparam int PHY_REG_BITS   = 6;
  localparam int LOG_REG_BITS   = 5;
  typedef logic [ROB_DEPTH_BITS:0] rob_tag_t;
  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    uses_rw;
    logic [LOG_REG_BITS-1:0] rw_log;
    logic [PHY_REG_BITS-1:0] rw_phy;
    logic [PHY_REG_BITS-1:0] prev_phy;
  } rob_entry_t;
  // a is strictly younger than b when it lies further from the head in program order
  function automatic logic is_younger(rob_tag_t a, rob_tag_t b, rob_tag_t head);
    return rob_tag_t'(a - head) > rob_tag_t'(b - head);
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with allocate, writeback, commit and mispredict squash
//   clk, rst_n (sync, active-low)
//   alloc_*     : dispatch request and fields; alloc_ready/alloc_tag back to rename
//   wb_valid/wb_tag : execution completion
//   flush/flush_tag : squash everything younger than the mispredicted branch
//   reg_wr_en, commit_* : head retirement to rename/free list
//   rob_empty, rob_count : occupancy
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  input  logic                      alloc_uses_rw,
  input  logic [LOG_REG_BITS-1:0]   alloc_rw_log,
  input  logic [PHY_REG_BITS-1:0]   alloc_rw_phy,
  input  logic [PHY_REG_BITS-1:0]   alloc_prev_phy,
  output logic                      alloc_ready,
  output logic [ROB_DEPTH_BITS:0]   alloc_tag,
  input  logic                      wb_valid,
  input  logic [ROB_DEPTH_BITS:0]   wb_tag,
  input  logic                      flush,
  input  logic [ROB_DEPTH_BITS:0]   flush_tag,
  output logic                      reg_wr_en,
  output logic [PHY_REG_BITS-1:0]   commit_reg,
  output logic [LOG_REG_BITS-1:0]   commit_log,
  output logic [PHY_REG_BITS-1:0]   commit_free_phy,
  output logic                      commit_valid,
  output logic                      rob_empty,
  output logic [ROB_DEPTH_BITS:0]   rob_count
);
  rob_entry_t rob [ROB_DEPTH];
  rob_tag_t head, tail;
  logic [ROB_DEPTH_BITS-1:0] head_idx, tail_idx, wb_idx;
  logic [ROB_DEPTH-1:0] kill;
  logic alloc_fire, wb_hit;
  rob_entry_t head_e;
  assign head_idx  = head[ROB_DEPTH_BITS-1:0];
  assign tail_idx  = tail[ROB_DEPTH_BITS-1:0];
  assign wb_idx    = wb_tag[ROB_DEPTH_BITS-1:0];
  assign rob_count = tail - head;
  assign rob_empty = head == tail;
  assign alloc_ready = !rob_count[ROB_DEPTH_BITS] && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;
  assign head_e       = rob[head_idx];
  assign commit_valid = !rob_empty && head_e.valid && head_e.done;
  assign reg_wr_en    = commit_valid && head_e.uses_rw;
  assign commit_reg      = head_e.rw_phy;
  assign commit_log      = head_e.rw_log;
  assign commit_free_phy = head_e.prev_phy;
  // a tag inside [head, tail) carries the live wrap bit; anything else is a squashed leftover
  assign wb_hit = wb_valid && rob[wb_idx].valid && is_younger(tail, wb_tag, head);
  // rebuild each slot's full tag from its distance to head, then squash (flush_tag, tail)
  always_comb begin
    kill = '0;
    for (int i = 0; i < ROB_DEPTH; i++)
      kill[i] = flush
        && is_younger(head + rob_tag_t'(ROB_DEPTH_BITS'(i) - head_idx), flush_tag, head)
        && is_younger(tail, head + rob_tag_t'(ROB_DEPTH_BITS'(i) - head_idx), head);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].done  <= 1'b0;
      end
    end else begin
      if (alloc_fire)
        rob[tail_idx] <= '{valid: 1'b1, done: 1'b0, uses_rw: alloc_uses_rw,
                           rw_log: alloc_rw_log, rw_phy: alloc_rw_phy, prev_phy: alloc_prev_phy};
      if (wb_hit) rob[wb_idx].done <= 1'b1;
      if (commit_valid) rob[head_idx].valid <= 1'b0;
      for (int i = 0; i < ROB_DEPTH; i++)
        if (kill[i]) rob[i].valid <= 1'b0;
      head <= head + rob_tag_t'(commit_valid);
      tail <= flush ? flush_tag + rob_tag_t'(1) : tail + rob_tag_t'(alloc_fire);
    end
  end
  a_flush_tag_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    flush |-> is_younger(tail, flush_tag, head));
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scoreboard bench for reorder_buffer
module tb_reorder_buffer;
  import rob_pkg::*;
  logic clk = 0, rst_n = 0;
  logic alloc_valid = 0, alloc_uses_rw = 0;
  logic [LOG_REG_BITS-1:0] alloc_rw_log = '0;
  logic [PHY_REG_BITS-1:0] alloc_rw_phy = '0, alloc_prev_phy = '0;
  logic alloc_ready;
  logic [ROB_DEPTH_BITS:0] alloc_tag;
  logic wb_valid = 0, flush = 0;
  logic [ROB_DEPTH_BITS:0] wb_tag = '0, flush_tag = '0;
  logic reg_wr_en, commit_valid, rob_empty;
  logic [PHY_REG_BITS-1:0] commit_reg, commit_free_phy;
  logic [LOG_REG_BITS-1:0] commit_log;
  logic [ROB_DEPTH_BITS:0] rob_count;
  typedef struct packed {
    logic uses;
    logic [LOG_REG_BITS-1:0] log;
    logic [PHY_REG_BITS-1:0] phy;
    logic [PHY_REG_BITS-1:0] prev;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, commits = 0;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_uses_rw(alloc_uses_rw), .alloc_rw_log(alloc_rw_log),
    .alloc_rw_phy(alloc_rw_phy), .alloc_prev_phy(alloc_prev_phy),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush), .flush_tag(flush_tag),
    .reg_wr_en(reg_wr_en), .commit_reg(commit_reg), .commit_log(commit_log),
    .commit_free_phy(commit_free_phy), .commit_valid(commit_valid),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && commit_valid) begin
      commits++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got reg %0d expected no commit", commit_reg);
      end else begin
        e = sb.pop_front();
        chk("commit_reg", commit_reg, e.phy);
        chk("commit_log", commit_log, e.log);
        chk("commit_free_phy", commit_free_phy, e.prev);
        chk("reg_wr_en", reg_wr_en, e.uses);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; alloc_valid = 0; wb_valid = 0; flush = 0;
    step; step;
    rst_n = 1;
    sb.delete();
  endtask

  task automatic alloc(int tag, int phy, int prev, int log, bit uses);
    alloc_valid = 1; alloc_uses_rw = uses;
    alloc_rw_phy = PHY_REG_BITS'(phy); alloc_prev_phy = PHY_REG_BITS'(prev);
    alloc_rw_log = LOG_REG_BITS'(log);
    @(negedge clk);
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_tag", alloc_tag, tag);
    step;
    alloc_valid = 0;
    sb.push_back('{uses, LOG_REG_BITS'(log), PHY_REG_BITS'(phy), PHY_REG_BITS'(prev)});
  endtask

  task automatic wb(int tag);
    wb_valid = 1; wb_tag = (ROB_DEPTH_BITS + 1)'(tag);
    step;
    wb_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    do_reset;
    @(negedge clk);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_count", rob_count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_reg_wr_en", reg_wr_en, 0);
    step;
    for (int i = 0; i < 3; i++) alloc(i, 32 + i, 1 + i, 5 + i, 1);
    @(negedge clk);
    chk("count3", rob_count, 3);
    chk("no_commit_before_wb", commit_valid, 0);
    step;
    wb_valid = 1; wb_tag = 2;
    step;
    @(negedge clk);
    chk("no_commit_out_of_order", commit_valid, 0);
    wb_tag = 0;
    step;
    wb_tag = 1;
    @(negedge clk);
    chk("first_commit_latency", commit_valid, 1);
    step;
    wb_valid = 0;
    repeat (3) step;
    @(negedge clk);
    chk("in_order_empty", rob_empty, 1);
    chk("in_order_commits", commits, 3);

    do_reset;
    for (int i = 0; i < 16; i++) alloc(i, 40 + i, i, i, i % 2);
    @(negedge clk);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", rob_count, 16);
    step;
    alloc_valid = 1; alloc_uses_rw = 1; alloc_rw_phy = 60; alloc_prev_phy = 20; alloc_rw_log = 20;
    wb_valid = 1; wb_tag = 0;
    step;
    wb_valid = 0;
    @(negedge clk);
    chk("full_commit", commit_valid, 1);
    chk("full_no_bypass", alloc_ready, 0);
    step;
    @(negedge clk);
    chk("ready_after_commit", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 16);
    step;
    alloc_valid = 0;
    sb.push_back('{1'b1, 5'd20, 6'd60, 6'd20});
    @(negedge clk);
    chk("refill_count", rob_count, 16);

    do_reset;
    for (int i = 0; i < 6; i++) alloc(i, 10 + i, 50 + i, 10 + i, 1);
    flush = 1; flush_tag = 2;
    @(negedge clk);
    chk("flush_blocks_alloc", alloc_ready, 0);
    step;
    flush = 0;
    repeat (3) void'(sb.pop_back());
    @(negedge clk);
    chk("flush_count", rob_count, 3);
    chk("flush_next_tag", alloc_tag, 3);
    step;
    wb(4);
    alloc(3, 30, 31, 3, 1);
    alloc(4, 35, 36, 4, 0);
    wb(20);
    for (int i = 0; i < 4; i++) wb(i);
    repeat (3) step;
    @(negedge clk);
    chk("stale_wb_ignored", rob_count, 1);
    chk("stale_no_commit", commit_valid, 0);
    step;
    wb(4);
    step;
    @(negedge clk);
    chk("flush_drain_empty", rob_empty, 1);

    do_reset;
    for (int i = 0; i < 4; i++) alloc(i, 20 + i, 40 + i, 1 + i, 1);
    wb(0);
    flush = 1; flush_tag = 1;
    alloc_valid = 1; alloc_rw_phy = 63; alloc_prev_phy = 62; alloc_rw_log = 31;
    @(negedge clk);
    chk("flush_commit_pulse", commit_valid, 1);
    chk("flush_commit_ready", alloc_ready, 0);
    step;
    flush = 0; alloc_valid = 0;
    repeat (2) void'(sb.pop_back());
    @(negedge clk);
    chk("flush_commit_count", rob_count, 1);
    chk("flush_commit_tag", alloc_tag, 2);
    step;
    wb(1);
    @(negedge clk);
    chk("survivor_commit", commit_valid, 1);
    step;
    @(negedge clk);
    chk("survivor_empty", rob_empty, 1);

    do_reset;
    for (int i = 0; i < 5; i++) alloc(i, i, i, i, 1);
    wb_valid = 1; wb_tag = 0;
    rst_n = 0;
    step;
    rst_n = 1; wb_valid = 0;
    sb.delete();
    @(negedge clk);
    chk("midrst_empty", rob_empty, 1);
    chk("midrst_count", rob_count, 0);
    chk("midrst_commit", commit_valid, 0);
    chk("midrst_tag", alloc_tag, 0);
    step;
    wb(0);
    @(negedge clk);
    chk("midrst_no_late_commit", commit_valid, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
